// File: rtl/yj_engine_rr_arbiter_if.sv
// Requester/engine bundle for yj_engine_rr_arbiter.
//   req/req_dat       : per-requester request level and operand (slice i = [i*DW +: DW])
//   gnt/rsp_vld       : one-hot grant (ISSUE..RESP) and one-cycle response strobe
//   rsp_dat           : engine result returned to the winner
//   eng_start/eng_dat : start pulse and operand towards the engine
//   eng_done/eng_res  : completion pulse and result from the engine
//   busy              : arbiter is not idle
// slave  : arbiter side.  master : requesters + engine side.
interface yj_engine_rr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_dat;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_vld;
  logic [DW-1:0]      rsp_dat;
  logic               eng_start;
  logic [DW-1:0]      eng_dat;
  logic               eng_done;
  logic [DW-1:0]      eng_res;
  logic               busy;

  modport master (
    output req, req_dat, eng_done, eng_res,
    input  gnt, rsp_vld, rsp_dat, eng_start, eng_dat, busy
  );

  modport slave (
    input  req, req_dat, eng_done, eng_res,
    output gnt, rsp_vld, rsp_dat, eng_start, eng_dat, busy
  );
endinterface

// File: rtl/yj_engine_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle engine between NREQ requesters.
// One transaction at a time: IDLE (arbitrate, latch operand) -> ISSUE (start
// pulse) -> WAIT (until eng_done) -> RESP (return result, rotate priority).
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : yj_engine_rr_arbiter_if.slave (requester and engine signals)
// All outputs are registered.
module yj_engine_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input logic                   CLK,
  input logic                   RST,
  yj_engine_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  state_t          r_state,     w_state_nxt;
  logic [IW-1:0]   r_ptr,       w_ptr_nxt;
  logic [IW-1:0]   r_idx,       w_idx_nxt;
  logic [NREQ-1:0] r_gnt,       w_gnt_nxt;
  logic [NREQ-1:0] r_rsp_vld,   w_rsp_vld_nxt;
  logic [DW-1:0]   r_rsp_dat,   w_rsp_dat_nxt;
  logic [DW-1:0]   r_eng_dat,   w_eng_dat_nxt;
  logic            r_eng_start, w_eng_start_nxt;
  logic            r_busy,      w_busy_nxt;

  logic            w_win_vld;
  logic [IW-1:0]   w_win_idx;
  logic [IW-1:0]   w_cand;
  logic [DW-1:0]   w_win_dat;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_idx_oh;

  // Rotating-priority search: first request at or after r_ptr, modulo NREQ.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IW'((32'(r_ptr) + k) % NREQ);
      if (!w_win_vld && bus.req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // Winner operand mux; constant slice bases keep the select simple.
  always_comb begin
    w_win_dat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_win_dat = bus.req_dat[i*DW +: DW];
      end
    end
  end

  assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_idx_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_idx_nxt       = r_idx;
    w_gnt_nxt       = r_gnt;
    w_rsp_vld_nxt   = '0;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_eng_dat_nxt   = r_eng_dat;
    w_eng_start_nxt = 1'b0;
    w_busy_nxt      = r_busy;

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_win_vld) begin
          w_state_nxt     = S_ISSUE;
          w_idx_nxt       = w_win_idx;
          w_eng_dat_nxt   = w_win_dat;
          w_gnt_nxt       = w_win_oh;
          w_eng_start_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          w_state_nxt   = S_RESP;
          w_rsp_dat_nxt = bus.eng_res;
          w_rsp_vld_nxt = w_idx_oh;
        end
      end
      S_RESP: begin
        // Winner becomes lowest priority for the next arbitration.
        w_ptr_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_rsp_vld   <= '0;
      r_rsp_dat   <= '0;
      r_eng_dat   <= '0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_idx       <= w_idx_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rsp_vld   <= w_rsp_vld_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_eng_dat   <= w_eng_dat_nxt;
      r_eng_start <= w_eng_start_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_vld   = r_rsp_vld;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.eng_start = r_eng_start;
  assign bus.eng_dat   = r_eng_dat;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_yj_engine_rr_arbiter.sv
// Self-checking bench for yj_engine_rr_arbiter: directed vector table,
// fairness sequence, then randomized traffic against a transaction model.
module tb_yj_engine_rr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h4444_0003;

  logic CLK;
  logic RST;

  yj_engine_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  yj_engine_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    bit          done;
    logic [31:0] res;
    logic [3:0]  gnt;
    bit          st;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [31:0] ed;
    bit          busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state (transaction level).
  int          m_owner;
  int          m_ptr;
  int          m_start_c;
  int          m_rsp_c;
  logic [31:0] m_ed;
  logic [31:0] m_rd;

  // Inputs applied during the previous cycle.
  bit          p_rst;
  logic [3:0]  p_req;
  logic [31:0] p_dat [4];
  bit          p_done;
  logic [31:0] p_res;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input bit done,
                     input logic [31:0] res, input logic [3:0] gnt, input bit st,
                     input logic [3:0] rv, input logic [31:0] rd,
                     input logic [31:0] ed, input bit busy);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.res = res;
    v.gnt = gnt; v.st = st; v.rv = rv; v.rd = rd; v.ed = ed; v.busy = busy;
    tbl.push_back(v);
  endtask

  // First requester at or after ptr, wrapping around.
  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_start_c = -10; m_rsp_c = -10;
    m_ed = '0; m_rd = '0;
  endtask

  // Advance the model by the previous cycle's inputs and compare the current outputs.
  task automatic model_check();
    logic [3:0] eg;
    logic [3:0] erv;
    if (p_rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (p_req != 0) begin
        m_owner   = pick(p_req, m_ptr);
        m_ed      = p_dat[m_owner];
        m_start_c = cyc;
      end
    end else if (cyc - 1 == m_start_c) begin
      // engine was only just started; a done here is spurious
    end else if (cyc - 1 == m_rsp_c) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (p_done) begin
      m_rd    = p_res;
      m_rsp_c = cyc;
    end
    eg  = (m_owner >= 0) ? (4'(1) << m_owner) : 4'd0;
    erv = (m_owner >= 0 && m_rsp_c == cyc) ? (4'(1) << m_owner) : 4'd0;
    chk($sformatf("rnd_gnt@%0d", cyc),     64'(bus.gnt),       64'(eg));
    chk($sformatf("rnd_start@%0d", cyc),   64'(bus.eng_start), 64'(m_owner >= 0 && m_start_c == cyc));
    chk($sformatf("rnd_rsp_vld@%0d", cyc), 64'(bus.rsp_vld),   64'(erv));
    chk($sformatf("rnd_rsp_dat@%0d", cyc), 64'(bus.rsp_dat),   64'(m_rd));
    chk($sformatf("rnd_eng_dat@%0d", cyc), 64'(bus.eng_dat),   64'(m_ed));
    chk($sformatf("rnd_busy@%0d", cyc),    64'(bus.busy),      64'(m_owner >= 0));
  endtask

  initial begin
    int          order[$];
    int          done_at;
    int          st_c;
    int          grants;
    int          starts;
    int          rsps;
    logic [3:0]  prev_g;
    bit          pend [4];
    bit          blk  [4];
    int          rel  [4];
    logic [31:0] rdat [4];
    bit          r;

    CLK = 1'b0;
    RST = 1'b1;
    bus.req      = '0;
    bus.req_dat  = {D3, D2, D1, D0};
    bus.eng_done = 1'b0;
    bus.eng_res  = '0;

    //   rst req done res           | gnt st rv rd            ed  busy
    add(1, 4'h0, 0, 32'h0,           4'h0, 0, 4'h0, 32'h0,     32'h0, 0);
    add(0, 4'h4, 0, 32'h0,           4'h4, 1, 4'h0, 32'h0,     D2, 1);
    add(0, 4'h4, 0, 32'h0,           4'h4, 0, 4'h0, 32'h0,     D2, 1);
    add(0, 4'h4, 1, 32'h0000_1234,   4'h4, 0, 4'h4, 32'h1234,  D2, 1);
    add(0, 4'h4, 0, 32'h0,           4'h0, 0, 4'h0, 32'h1234,  D2, 0);
    add(0, 4'h0, 1, 32'h5555,        4'h0, 0, 4'h0, 32'h1234,  D2, 0);
    add(0, 4'h3, 0, 32'h0,           4'h1, 1, 4'h0, 32'h1234,  D0, 1);
    add(0, 4'h3, 1, 32'h7777,        4'h1, 0, 4'h0, 32'h1234,  D0, 1);
    add(0, 4'h3, 0, 32'h0,           4'h1, 0, 4'h0, 32'h1234,  D0, 1);
    add(0, 4'h3, 1, 32'hABCD,        4'h1, 0, 4'h1, 32'hABCD,  D0, 1);
    add(0, 4'h3, 0, 32'h0,           4'h0, 0, 4'h0, 32'hABCD,  D0, 0);
    add(0, 4'h3, 0, 32'h0,           4'h2, 1, 4'h0, 32'hABCD,  D1, 1);
    add(0, 4'h3, 0, 32'h0,           4'h2, 0, 4'h0, 32'hABCD,  D1, 1);
    add(0, 4'h1, 0, 32'h0,           4'h2, 0, 4'h0, 32'hABCD,  D1, 1);
    add(0, 4'h1, 1, 32'hCAFE,        4'h2, 0, 4'h2, 32'hCAFE,  D1, 1);
    add(0, 4'h1, 0, 32'h0,           4'h0, 0, 4'h0, 32'hCAFE,  D1, 0);
    add(0, 4'h8, 0, 32'h0,           4'h8, 1, 4'h0, 32'hCAFE,  D3, 1);
    add(0, 4'h8, 0, 32'h0,           4'h8, 0, 4'h0, 32'hCAFE,  D3, 1);
    add(1, 4'h8, 0, 32'h0,           4'h0, 0, 4'h0, 32'h0,     32'h0, 0);
    add(0, 4'h0, 1, 32'hBAD0,        4'h0, 0, 4'h0, 32'h0,     32'h0, 0);
    add(0, 4'h0, 0, 32'h0,           4'h0, 0, 4'h0, 32'h0,     32'h0, 0);
    add(0, 4'hA, 0, 32'h0,           4'h2, 1, 4'h0, 32'h0,     D1, 1);
    add(0, 4'hA, 0, 32'h0,           4'h2, 0, 4'h0, 32'h0,     D1, 1);
    add(0, 4'hA, 1, 32'h1,           4'h2, 0, 4'h2, 32'h1,     D1, 1);
    add(0, 4'hA, 0, 32'h0,           4'h0, 0, 4'h0, 32'h1,     D1, 0);
    add(0, 4'h8, 0, 32'h0,           4'h8, 1, 4'h0, 32'h1,     D3, 1);
    add(0, 4'h8, 0, 32'h0,           4'h8, 0, 4'h0, 32'h1,     D3, 1);
    add(0, 4'h8, 1, 32'h2,           4'h8, 0, 4'h8, 32'h2,     D3, 1);
    add(0, 4'h0, 0, 32'h0,           4'h0, 0, 4'h0, 32'h2,     D3, 0);

    // Directed vectors: inputs held for one cycle, outputs checked in the next.
    for (int i = 0; i < tbl.size(); i++) begin
      RST          = tbl[i].rst;
      bus.req      = tbl[i].req;
      bus.eng_done = tbl[i].done;
      bus.eng_res  = tbl[i].res;
      step();
      chk($sformatf("row%0d_gnt", i),     64'(bus.gnt),       64'(tbl[i].gnt));
      chk($sformatf("row%0d_start", i),   64'(bus.eng_start), 64'(tbl[i].st));
      chk($sformatf("row%0d_rsp_vld", i), 64'(bus.rsp_vld),   64'(tbl[i].rv));
      chk($sformatf("row%0d_rsp_dat", i), 64'(bus.rsp_dat),   64'(tbl[i].rd));
      chk($sformatf("row%0d_eng_dat", i), 64'(bus.eng_dat),   64'(tbl[i].ed));
      chk($sformatf("row%0d_busy", i),    64'(bus.busy),      64'(tbl[i].busy));
    end

    // Fairness: all requesters active, engine done 3 cycles after each start.
    RST = 1'b1; bus.req = '0; bus.eng_done = 1'b0;
    step();
    RST = 1'b0;
    bus.req = 4'hF;
    done_at = -100; grants = 0; starts = 0; rsps = 0; prev_g = '0;
    for (int b = 0; b < 200 && order.size() < 5; b++) begin
      bus.eng_done = (cyc == done_at);
      bus.eng_res  = 32'(cyc);
      step();
      if (bus.eng_start) begin
        starts++;
        for (int k = 0; k < 4; k++) if (bus.gnt[k]) order.push_back(k);
        done_at = cyc + 3;
      end
      if (bus.gnt != 0 && prev_g == 0) grants++;
      if (bus.rsp_vld != 0) rsps++;
      prev_g = bus.gnt;
    end
    chk("fair_grant_count", 64'(order.size()), 64'(5));
    for (int k = 0; k < order.size(); k++)
      chk($sformatf("fair_order%0d", k), 64'(order[k]), 64'(k % 4));
    chk("fair_start_per_grant", 64'(starts), 64'(grants));
    chk("fair_rsp_count", 64'(rsps), 64'(4));

    // Randomized traffic against the model.
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0; blk[i] = 0; rel[i] = 0; rdat[i] = '0; p_dat[i] = '0;
    end
    RST = 1'b1; bus.req = '0; bus.eng_done = 1'b0; bus.eng_res = '0;
    p_rst = 1'b1; p_req = '0; p_done = 1'b0; p_res = '0;
    step();
    model_check();
    done_at = -100; st_c = -100;
    for (int it = 0; it < 2000; it++) begin
      r = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 4; i++) begin
        if (rel[i] == 1) begin pend[i] = 0; blk[i] = 0; end
        if (rel[i] > 0) rel[i]--;
        if (r) blk[i] = 0;
        if (!pend[i] && !blk[i] && rel[i] == 0 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          rdat[i] = $urandom;
        end else if (blk[i]) begin
          rdat[i] = $urandom;
        end
      end
      RST          = r;
      bus.req      = {pend[3], pend[2], pend[1], pend[0]};
      bus.req_dat  = {rdat[3], rdat[2], rdat[1], rdat[0]};
      bus.eng_done = (cyc == done_at) ||
                     (!(cyc > st_c && cyc < done_at) && $urandom_range(0, 3) == 0);
      bus.eng_res  = $urandom;
      p_rst = RST; p_req = bus.req; p_done = bus.eng_done; p_res = bus.eng_res;
      for (int i = 0; i < 4; i++) p_dat[i] = rdat[i];
      step();
      model_check();
      if (bus.eng_start) begin
        st_c    = cyc;
        done_at = cyc + int'($urandom_range(1, 4));
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.rsp_vld[i]) rel[i] = 2;
        if (bus.gnt[i] && pend[i] && rel[i] == 0 && $urandom_range(0, 9) == 0) begin
          pend[i] = 0;
          blk[i]  = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
